branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4, number of direct-mapped entries (power of 2, >= 2).
REQ-002 SHALL have parameter TAG_W, default 8, stored tag width; IDX_W = $clog2(N_ENTRIES); TAG_W + IDX_W + 2 <= 64.
REQ-003 SHALL have parameter CNT_W, default 2, saturating-counter width (1..4).
REQ-004 SHALL have port clk  in  1  single clock; all state rises on posedge.
REQ-005 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IF_PC  in  64  fetch PC for lookup.
REQ-007 SHALL have port predictedBranchPC  out  64  target of the hit entry, 0 on miss.
REQ-008 SHALL have port branchTaken  out  1  predict-taken for IF_PC.
REQ-009 SHALL have port btbHit  out  1  valid entry with matching tag.
REQ-010 SHALL have port upd_valid  in  1  resolved conditional branch this cycle.
REQ-011 SHALL have port upd_pc  in  64  PC of the resolved branch.
REQ-012 SHALL have port upd_target  in  64  computed branch target.
REQ-013 SHALL have port upd_taken  in  1  actual outcome.
REQ-014 SHALL have port upd_mispredict  in  1  front end mispredicted this branch.
REQ-015 SHALL have port flush  in  1  invalidate all entries.
REQ-016 SHALL have port mispredictCount  out  32  saturating mispredict counter.

Function
REQ-017 SHALL index entries with pc[IDX_W+1:2] and tag with pc[IDX_W+TAG_W+1:IDX_W+2], for lookup and update alike.
REQ-018 SHALL assert btbHit combinationally when valid[idx] is set and tag[idx] equals the IF_PC tag.
REQ-019 SHALL drive branchTaken = btbHit AND cnt[idx] MSB, and predictedBranchPC = target[idx] on hit, else 0.
REQ-020 SHALL on an update hit (valid and tag match at upd index) increment cnt when taken, decrement when not, saturating at 2^CNT_W-1 and 0.
REQ-021 SHALL on an update hit with upd_taken=1 overwrite target with upd_target; target SHALL be unchanged when not taken.
REQ-022 SHALL on an update miss with upd_taken=1 allocate: set valid, write tag and target, and set cnt to 2^(CNT_W-1) (weakly taken).
REQ-023 SHALL on an update miss with upd_taken=0 leave the entry unchanged (no allocate).
REQ-024 SHALL make update effects visible to lookup the cycle after the update edge; a same-cycle lookup of the updated index SHALL see old state (no bypass).
REQ-025 SHALL on flush=1 clear all valid bits at the next edge; tags, targets and counters are retained but are unused until reallocated.
REQ-026 SHALL, when flush and upd_valid coincide, apply the flush only and drop the update.
REQ-027 SHALL increment mispredictCount when upd_valid AND upd_mispredict, hold at 0xFFFF_FFFF, and leave it unaffected by flush.
REQ-028 SHALL ignore all upd_* inputs while upd_valid=0.

Reset
REQ-029 SHALL on arst_n=0 asynchronously clear every valid bit, tag, target, counter and mispredictCount to 0.
REQ-030 SHALL drive btbHit=0, branchTaken=0 and predictedBranchPC=0 during and immediately after reset.
REQ-031 SHALL perform normal updates from the first posedge after arst_n deasserts.

Structure
REQ-032 SHALL take the counter-state constants (CNT_MAX, CNT_WEAK_TAKEN) and the index/tag slicing widths from shared package bp_pkg.
REQ-033 SHALL place the per-entry saturating up/down counter in sub-module bp_sat_counter (parameter CNT_W; inputs en, up; output cnt).
REQ-034 SHALL implement the storage as flops (no SRAM macro) with a combinational read path.

Verification (N_ENTRIES=4, TAG_W=8, CNT_W=2)
REQ-035 SHALL cover: reset, then lookup IF_PC=0x100 -> btbHit=0, branchTaken=0, predictedBranchPC=0.
REQ-036 SHALL cover: update pc=0x100, target=0x200, taken=1 -> next cycle lookup 0x100 gives hit=1, taken=1, PC=0x200, cnt=2.
REQ-037 SHALL cover: two not-taken updates at 0x100 -> cnt 2->1->0, branchTaken=0, hit=1; a third not-taken keeps cnt=0.
REQ-038 SHALL cover: alias pc=0x110 (same index, different tag) with taken=1 -> entry replaced; lookup 0x100 misses and 0x110 hits with new target.
REQ-039 SHALL cover: flush with a coincident taken update at 0x104 -> all entries miss next cycle and 0x104 is not allocated.
REQ-040 SHALL cover: 3 updates with upd_mispredict=1, then arst_n pulsed mid-stream -> mispredictCount reads 3, then 0 asynchronously.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor constants and helper functions
// Provides the PC field positions and the counter-state constants
// (CNT_MAX, CNT_WEAK_TAKEN) as width-parameterised functions.
// The index and tag widths are derived here as well.
// No ports.
package bp_pkg;

   localparam int PC_W    = 64;
   localparam int IDX_LSB = 2;   // instructions are word aligned, bits [1:0] never index

   function automatic int idx_w(input int n_entries);
      return $clog2(n_entries);
   endfunction

   // Tag field starts directly above the index field.
   function automatic int tag_lsb(input int n_entries);
      return IDX_LSB + $clog2(n_entries);
   endfunction

   // CNT_MAX: saturated strongly-taken state.
   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   // CNT_WEAK_TAKEN: lowest state whose MSB predicts taken.
   function automatic int cnt_weak_taken(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - per-entry saturating up/down prediction counter
// Ports: clk, arst_n (async active-low clear to 0),
//        en/up (count toward taken when up=1, toward not-taken when up=0),
//        load/load_val (overrides counting, used on allocation),
//        cnt (current counter state).
module bp_sat_counter
   import bp_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         if (up && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
         end else if (!up && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit style predictors
// Ports: clk, arst_n (async active-low);
//        lookup: IF_PC -> btbHit, branchTaken, predictedBranchPC (combinational);
//        update: upd_valid, upd_pc, upd_target, upd_taken, upd_mispredict;
//        flush (invalidate all entries); mispredictCount (saturating 32-bit).
module branch_target_buffer
   import bp_pkg::*;
#(
   parameter int N_ENTRIES = 4,
   parameter int TAG_W     = 8,
   parameter int CNT_W     = 2
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [63:0] IF_PC,
   output logic [63:0] predictedBranchPC,
   output logic        branchTaken,
   output logic        btbHit,
   input  logic        upd_valid,
   input  logic [63:0] upd_pc,
   input  logic [63:0] upd_target,
   input  logic        upd_taken,
   input  logic        upd_mispredict,
   input  logic        flush,
   output logic [31:0] mispredictCount
);

   localparam int IDX_W   = idx_w(N_ENTRIES);
   localparam int TAG_LSB = tag_lsb(N_ENTRIES);
   localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(cnt_weak_taken(CNT_W));

   logic             valid_q  [N_ENTRIES];
   logic [TAG_W-1:0] tag_q    [N_ENTRIES];
   logic [63:0]      target_q [N_ENTRIES];
   logic [CNT_W-1:0] cnt_q    [N_ENTRIES];

   logic [IDX_W-1:0] lu_idx;
   logic [TAG_W-1:0] lu_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             upd_go;
   logic             unused_pc_bits;

   assign lu_idx  = IF_PC[IDX_LSB +: IDX_W];
   assign lu_tag  = IF_PC[TAG_LSB +: TAG_W];
   assign upd_idx = upd_pc[IDX_LSB +: IDX_W];
   assign upd_tag = upd_pc[TAG_LSB +: TAG_W];

   // PC bits outside the index/tag fields do not participate.
   assign unused_pc_bits = ^{IF_PC, upd_pc};

   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   assign btbHit            = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
   assign branchTaken       = btbHit && cnt_q[lu_idx][CNT_W-1];
   assign predictedBranchPC = btbHit ? target_q[lu_idx] : 64'd0;

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   // Flush wins over a coincident update.
   assign upd_go  = upd_valid && !flush;

   for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
      logic sel;
      logic cnt_en;
      logic alloc;

      assign sel    = upd_go && (upd_idx == IDX_W'(i));
      assign cnt_en = sel && upd_hit;
      // Not-taken misses are never allocated; they would only pollute the table.
      assign alloc  = sel && !upd_hit && upd_taken;

      bp_sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk      (clk),
         .arst_n   (arst_n),
         .en       (cnt_en),
         .up       (upd_taken),
         .load     (alloc),
         .load_val (CNT_WEAK_TAKEN),
         .cnt      (cnt_q[i])
      );

      always_ff @(posedge clk or negedge arst_n) begin
         if (!arst_n) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end else if (flush) begin
            valid_q[i]  <= 1'b0;
         end else if (alloc) begin
            valid_q[i]  <= 1'b1;
            tag_q[i]    <= upd_tag;
            target_q[i] <= upd_target;
         end else if (cnt_en && upd_taken) begin
            target_q[i] <= upd_target;
         end
      end
   end

   // Statistics counter; flush does not touch it.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mispredictCount <= '0;
      end else if (upd_valid && upd_mispredict && (mispredictCount != 32'hFFFF_FFFF)) begin
         mispredictCount <= mispredictCount + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [63:0] IF_PC;
   logic [63:0] predictedBranchPC;
   logic        branchTaken;
   logic        btbHit;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic [63:0] upd_target;
   logic        upd_taken;
   logic        upd_mispredict;
   logic        flush;
   logic [31:0] mispredictCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_target_buffer #(
      .N_ENTRIES (4),
      .TAG_W     (8),
      .CNT_W     (2)
   ) dut (
      .clk               (clk),
      .arst_n            (arst_n),
      .IF_PC             (IF_PC),
      .predictedBranchPC (predictedBranchPC),
      .branchTaken       (branchTaken),
      .btbHit            (btbHit),
      .upd_valid         (upd_valid),
      .upd_pc            (upd_pc),
      .upd_target        (upd_target),
      .upd_taken         (upd_taken),
      .upd_mispredict    (upd_mispredict),
      .flush             (flush),
      .mispredictCount   (mispredictCount)
   );

   typedef struct {
      logic [63:0] if_pc;
      logic        uv;
      logic [63:0] upc;
      logic [63:0] utgt;
      logic        ut;
      logic        flush;
      logic        exp_hit;
      logic        exp_taken;
      logic [63:0] exp_pc;
   } vec_t;

   vec_t vecs [17];

   // Reference model: 4 entries, 2-bit counters, taken when counter >= 2.
   bit          m_valid [4];
   int          m_tag   [4];
   logic [63:0] m_tgt   [4];
   int          m_cnt   [4];
   longint      m_misp;

   function automatic int idx_of(input logic [63:0] pc);
      return int'((pc >> 2) % 4);
   endfunction

   function automatic int tag_of(input logic [63:0] pc);
      return int'((pc >> 4) % 256);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = 64'd0;
         m_cnt[i]   = 0;
      end
      m_misp = 0;
   endtask

   task automatic model_update();
      int  i;
      int  t;
      if (upd_valid && upd_mispredict && m_misp < 64'hFFFF_FFFF) m_misp++;
      if (flush) begin
         for (int k = 0; k < 4; k++) m_valid[k] = 0;
      end else if (upd_valid) begin
         i = idx_of(upd_pc);
         t = tag_of(upd_pc);
         if (m_valid[i] && m_tag[i] == t) begin
            if (upd_taken) begin
               m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
               m_tgt[i] = upd_target;
            end else begin
               m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = t;
            m_tgt[i]   = upd_target;
            m_cnt[i]   = 2;
         end
      end
   endtask

   task automatic model_lookup_check(input string name);
      int  i;
      bit  hit;
      i   = idx_of(IF_PC);
      hit = m_valid[i] && (m_tag[i] == tag_of(IF_PC));
      chk({name, "_hit"},   64'(btbHit),      64'(hit));
      chk({name, "_taken"}, 64'(branchTaken), 64'(hit && m_cnt[i] >= 2));
      chk({name, "_pc"},    predictedBranchPC, hit ? m_tgt[i] : 64'd0);
   endtask

   task automatic drive(input logic [63:0] pc, input logic uv, input logic [63:0] upc,
                        input logic [63:0] utgt, input logic ut, input logic um, input logic fl);
      IF_PC          = pc;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_target     = utgt;
      upd_taken      = ut;
      upd_mispredict = um;
      flush          = fl;
   endtask

   // Leaves the bench at posedge+1 with reset released.
   task automatic do_reset();
      drive(64'h100, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      arst_n = 1'b0;
      #1;
      chk("rst_hit",   64'(btbHit),      64'd0);
      chk("rst_taken", 64'(branchTaken), 64'd0);
      chk("rst_pc",    predictedBranchPC, 64'd0);
      chk("rst_misp",  64'(mispredictCount), 64'd0);
      @(negedge clk);
      arst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_vecs();
      //            if_pc    uv upc      utgt     ut fl  hit tk  pc
      vecs[0]  = '{64'h100, 1, 64'h100, 64'h200, 1, 0,  0, 0, 64'h0};
      vecs[1]  = '{64'h100, 0, 64'h0,   64'h0,   0, 0,  1, 1, 64'h200};
      vecs[2]  = '{64'h100, 1, 64'h100, 64'h999, 0, 0,  1, 1, 64'h200};
      vecs[3]  = '{64'h100, 1, 64'h100, 64'h999, 0, 0,  1, 0, 64'h200};
      vecs[4]  = '{64'h100, 1, 64'h100, 64'h999, 0, 0,  1, 0, 64'h200};
      vecs[5]  = '{64'h100, 1, 64'h100, 64'h300, 1, 0,  1, 0, 64'h200};
      vecs[6]  = '{64'h100, 0, 64'h0,   64'h0,   0, 0,  1, 0, 64'h300};
      vecs[7]  = '{64'h110, 1, 64'h110, 64'h400, 1, 0,  0, 0, 64'h0};
      vecs[8]  = '{64'h100, 0, 64'h0,   64'h0,   0, 0,  0, 0, 64'h0};
      vecs[9]  = '{64'h110, 0, 64'h0,   64'h0,   0, 0,  1, 1, 64'h400};
      vecs[10] = '{64'h110, 1, 64'h104, 64'h500, 1, 1,  1, 1, 64'h400};
      vecs[11] = '{64'h110, 0, 64'h0,   64'h0,   0, 0,  0, 0, 64'h0};
      vecs[12] = '{64'h104, 0, 64'h0,   64'h0,   0, 0,  0, 0, 64'h0};
      vecs[13] = '{64'h104, 1, 64'h104, 64'h600, 0, 0,  0, 0, 64'h0};
      vecs[14] = '{64'h104, 0, 64'h0,   64'h0,   0, 0,  0, 0, 64'h0};
      vecs[15] = '{64'h108, 0, 64'h108, 64'h700, 1, 0,  0, 0, 64'h0};
      vecs[16] = '{64'h108, 0, 64'h0,   64'h0,   0, 0,  0, 0, 64'h0};
   endtask

   initial begin
      logic [63:0] rpc;
      logic [63:0] rupc;
      arst_n = 1'b1;
      drive(64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      #2;
      fill_vecs();

      // Directed table
      do_reset();
      for (int v = 0; v < 17; v++) begin
         drive(vecs[v].if_pc, vecs[v].uv, vecs[v].upc, vecs[v].utgt, vecs[v].ut, 1'b0, vecs[v].flush);
         #2;
         chk($sformatf("vec%0d_hit", v),   64'(btbHit),      64'(vecs[v].exp_hit));
         chk($sformatf("vec%0d_taken", v), 64'(branchTaken), 64'(vecs[v].exp_taken));
         chk($sformatf("vec%0d_pc", v),    predictedBranchPC, vecs[v].exp_pc);
         @(posedge clk);
         #1;
      end

      // Mispredict counting then asynchronous reset mid-stream
      do_reset();
      drive(64'h100, 1'b1, 64'h100, 64'h200, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("misp_1", 64'(mispredictCount), 64'd1);
      @(posedge clk); #1;
      chk("misp_2", 64'(mispredictCount), 64'd2);
      drive(64'h100, 1'b1, 64'h104, 64'h200, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("misp_3", 64'(mispredictCount), 64'd3);
      chk("misp_hit_before_rst", 64'(btbHit), 64'd1);
      #2;
      arst_n = 1'b0;
      #1;
      chk("misp_async_clear", 64'(mispredictCount), 64'd0);
      chk("async_rst_hit", 64'(btbHit), 64'd0);
      chk("async_rst_pc", predictedBranchPC, 64'd0);
      drive(64'h100, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_hit", 64'(btbHit), 64'd0);

      // Randomized against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rpc        = {$urandom, $urandom};
         rpc[11:4]  = 8'($urandom_range(0, 2));
         rpc[3:2]   = 2'($urandom_range(0, 3));
         rupc       = {$urandom, $urandom};
         rupc[11:4] = 8'($urandom_range(0, 2));
         rupc[3:2]  = 2'($urandom_range(0, 3));
         drive(rpc, 1'($urandom_range(0, 3) != 0), rupc, {$urandom, $urandom},
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 39) == 0));
         #2;
         model_lookup_check($sformatf("rand%0d", c));
         model_update();
         @(posedge clk); #1;
         chk($sformatf("rand%0d_misp", c), 64'(mispredictCount), 64'(m_misp));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
